// File: rtl/div_approx_err_monitor.sv
// div_approx_err_monitor
//   Scores an approximate 16/8 array divider. Each accepted operand pair is
//   re-divided exactly with an 8-cycle restoring divider. The squared error
//   and the peak absolute error against the divider's quotient are
//   accumulated over a window of 2**LOG2_SAMPLES in-range samples.
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   clear             synchronous clear of stats and FSM (mse is kept)
//   in_valid/in_ready sample handshake
//   n, d, q_apx       dividend, divisor, approximate quotient
//   sum_sq            running saturating sum of squared errors
//   max_abs           peak |q_ex - q_apx| in the current window
//   skip_cnt          saturating count of out-of-range samples
//   done              one-cycle pulse at window end
//   mse               sum_sq >> LOG2_SAMPLES, latched at window end
//   sat               sticky: sum_sq saturated in this window
module div_approx_err_monitor #(
    parameter int unsigned LOG2_SAMPLES = 10,
    parameter int unsigned ACCW         = 40
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clear,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [15:0]     n,
    input  logic [7:0]      d,
    input  logic [7:0]      q_apx,
    output logic [ACCW-1:0] sum_sq,
    output logic [7:0]      max_abs,
    output logic [15:0]     skip_cnt,
    output logic            done,
    output logic [ACCW-1:0] mse,
    output logic            sat
);

    localparam int unsigned CNTW = LOG2_SAMPLES + 1;
    localparam int unsigned WIN  = 2 ** LOG2_SAMPLES;

    typedef enum logic [1:0] {IDLE, DIV, ACC, DONE} state_t;

    state_t          state_q;
    logic            in_ready_q;
    logic            done_q;
    logic            sat_q;
    logic [7:0]      nlo_q;
    logic [7:0]      d_q;
    logic [7:0]      qapx_q;
    logic [7:0]      rem_q;
    logic [7:0]      qex_q;
    logic [2:0]      iter_q;
    logic [CNTW-1:0] cnt_q;
    logic [ACCW-1:0] sum_q;
    logic [ACCW-1:0] mse_q;
    logic [7:0]      max_q;
    logic [15:0]     skip_q;

    logic [8:0]      div_t;
    logic            div_ge;
    logic [7:0]      div_sub;
    logic [8:0]      err;
    logic [7:0]      abs_err;
    logic [15:0]     sq;
    logic [ACCW:0]   sum_ext;
    logic [ACCW-1:0] sum_d;
    logic [CNTW-1:0] cnt_d;
    logic            out_of_range;

    always_comb begin
        // One restoring step: shift the next dividend bit into the remainder.
        div_t        = {rem_q, nlo_q[iter_q]};
        div_ge       = div_t >= {1'b0, d_q};
        div_sub      = 8'(div_t - {1'b0, d_q});
        err          = {1'b0, qex_q} - {1'b0, qapx_q};
        abs_err      = err[8] ? 8'(9'd0 - err) : err[7:0];
        sq           = 16'(abs_err) * 16'(abs_err);
        // Extra carry bit detects accumulator overflow for saturation.
        sum_ext      = {1'b0, sum_q} + (ACCW + 1)'(sq);
        sum_d        = sum_ext[ACCW] ? '1 : sum_ext[ACCW-1:0];
        cnt_d        = cnt_q + CNTW'(1);
        // Quotient would not fit in 8 bits (or divide by zero).
        out_of_range = (d == '0) || (n[15:8] >= d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            in_ready_q <= 1'b1;
            done_q     <= 1'b0;
            sat_q      <= 1'b0;
            nlo_q      <= '0;
            d_q        <= '0;
            qapx_q     <= '0;
            rem_q      <= '0;
            qex_q      <= '0;
            iter_q     <= '0;
            cnt_q      <= '0;
            sum_q      <= '0;
            mse_q      <= '0;
            max_q      <= '0;
            skip_q     <= '0;
        end else if (clear) begin
            state_q    <= IDLE;
            in_ready_q <= 1'b1;
            done_q     <= 1'b0;
            sat_q      <= 1'b0;
            cnt_q      <= '0;
            sum_q      <= '0;
            max_q      <= '0;
            skip_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        if (out_of_range) begin
                            if (skip_q != 16'hFFFF) skip_q <= skip_q + 16'd1;
                        end else begin
                            nlo_q      <= n[7:0];
                            d_q        <= d;
                            qapx_q     <= q_apx;
                            rem_q      <= n[15:8];
                            qex_q      <= '0;
                            iter_q     <= 3'd7;
                            in_ready_q <= 1'b0;
                            state_q    <= DIV;
                        end
                    end
                end
                DIV: begin
                    rem_q         <= div_ge ? div_sub : div_t[7:0];
                    qex_q[iter_q] <= div_ge;
                    iter_q        <= iter_q - 3'd1;
                    if (iter_q == 3'd0) state_q <= ACC;
                end
                ACC: begin
                    sum_q <= sum_d;
                    if (sum_ext[ACCW]) sat_q <= 1'b1;
                    if (abs_err > max_q) max_q <= abs_err;
                    cnt_q <= cnt_d;
                    if (cnt_d == CNTW'(WIN)) begin
                        mse_q   <= sum_d >> LOG2_SAMPLES;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        in_ready_q <= 1'b1;
                        state_q    <= IDLE;
                    end
                end
                DONE: begin
                    done_q     <= 1'b0;
                    sum_q      <= '0;
                    max_q      <= '0;
                    sat_q      <= 1'b0;
                    cnt_q      <= '0;
                    in_ready_q <= 1'b1;
                    state_q    <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready = in_ready_q;
    assign sum_sq   = sum_q;
    assign max_abs  = max_q;
    assign skip_cnt = skip_q;
    assign done     = done_q;
    assign mse      = mse_q;
    assign sat      = sat_q;

endmodule

// File: tb/tb_div_approx_err_monitor.sv
module tb_div_approx_err_monitor;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] n = '0;
    logic [7:0]  d = '0;
    logic [7:0]  q_apx = '0;
    logic [15:0] sum_sq;
    logic [7:0]  max_abs;
    logic [15:0] skip_cnt;
    logic        done;
    logic [15:0] mse;
    logic        sat;

    div_approx_err_monitor #(.LOG2_SAMPLES(2), .ACCW(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (clear),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .n        (n),
        .d        (d),
        .q_apx    (q_apx),
        .sum_sq   (sum_sq),
        .max_abs  (max_abs),
        .skip_cnt (skip_cnt),
        .done     (done),
        .mse      (mse),
        .sat      (sat)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] sum;
        logic [7:0]  mx;
        logic        sat;
        logic        done;
        logic [15:0] mse;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Monitor: an event is the done pulse or in_ready rising after a busy period.
    logic prev_ready = 1'b1;
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_ready = 1'b1;
            end else begin
                if (done || (in_ready && !prev_ready)) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_event", 32'(done), 32'hDEAD);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        chk("ev_cycle",   32'(cyc),     32'(e.cyc));
                        chk("ev_sum_sq",  32'(sum_sq),  32'(e.sum));
                        chk("ev_max_abs", 32'(max_abs), 32'(e.mx));
                        chk("ev_sat",     32'(sat),     32'(e.sat));
                        chk("ev_done",    32'(done),    32'(e.done));
                        chk("ev_mse",     32'(mse),     32'(e.mse));
                    end
                end
                prev_ready = in_ready;
            end
        end
    end

    task automatic wait_ready();
        int w;
        w = 0;
        @(negedge clk);
        while (!in_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (w >= 100) chk("ready_timeout", 32'(in_ready), 32'd1);
    endtask

    task automatic send(input logic [15:0] nn, input logic [7:0] dd, input logic [7:0] qa,
                        output int acc_cyc);
        wait_ready();
        in_valid = 1'b1;
        n = nn;
        d = dd;
        q_apx = qa;
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        // Garbage after the handshake: the DUT must have captured the inputs.
        in_valid = 1'b0;
        n = 16'hFFFF;
        d = 8'h00;
        q_apx = 8'hA5;
    endtask

    task automatic sample(input logic [15:0] nn, input logic [7:0] dd, input logic [7:0] qa,
                          input logic [15:0] esum, input logic [7:0] emx, input logic esat,
                          input logic edone, input logic [15:0] emse);
        int c;
        exp_t e;
        send(nn, dd, qa, c);
        e.sum = esum; e.mx = emx; e.sat = esat; e.done = edone; e.mse = emse; e.cyc = c + 9;
        exp_q.push_back(e);
        if (edone) begin
            e.sum = '0; e.mx = '0; e.sat = 1'b0; e.done = 1'b0; e.cyc = c + 10;
            exp_q.push_back(e);
        end
    endtask

    initial begin
        int c;
        int w;

        // Reset values
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_sum_sq",   32'(sum_sq),   32'd0);
        chk("rst_max_abs",  32'(max_abs),  32'd0);
        chk("rst_skip_cnt", 32'(skip_cnt), 32'd0);
        chk("rst_done",     32'(done),     32'd0);
        chk("rst_mse",      32'(mse),      32'd0);
        chk("rst_sat",      32'(sat),      32'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;

        // Window 1: errors 0, 2, -2, 0 -> sum 8, mse 8>>2 = 2
        sample(16'd100, 8'd7, 8'd14, 16'd0, 8'd0, 1'b0, 1'b0, 16'd0);
        sample(16'd100, 8'd7, 8'd12, 16'd4, 8'd2, 1'b0, 1'b0, 16'd0);
        sample(16'd100, 8'd7, 8'd16, 16'd8, 8'd2, 1'b0, 1'b0, 16'd0);
        sample(16'd100, 8'd7, 8'd14, 16'd8, 8'd2, 1'b0, 1'b1, 16'd2);

        // Back-to-back out-of-range samples
        wait_ready();
        in_valid = 1'b1; n = 16'd5; d = 8'd0; q_apx = 8'd0;
        @(posedge clk);
        #1 n = 16'h0800; d = 8'd8;
        @(negedge clk);
        chk("skip1_cnt",   32'(skip_cnt), 32'd1);
        chk("skip1_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        chk("skip2_cnt",    32'(skip_cnt), 32'd2);
        chk("skip2_ready",  32'(in_ready), 32'd1);
        chk("skip2_sum_sq", 32'(sum_sq),   32'd0);

        // Window 2: errors 1, -2, 3, 0 -> sum 14, mse 3, max 3
        sample(16'd1000,  8'd9,   8'd110, 16'd1,  8'd1, 1'b0, 1'b0, 16'd2);
        sample(16'h1234,  8'd32,  8'd147, 16'd5,  8'd2, 1'b0, 1'b0, 16'd2);
        sample(16'd50000, 8'd200, 8'd247, 16'd14, 8'd3, 1'b0, 1'b0, 16'd2);
        sample(16'd255,   8'd1,   8'd255, 16'd14, 8'd3, 1'b0, 1'b1, 16'd3);

        // Saturation: errors 255, -255
        sample(16'd255, 8'd1, 8'd0,   16'd65025, 8'd255, 1'b0, 1'b0, 16'd3);
        sample(16'd0,   8'd1, 8'd255, 16'hFFFF,  8'd255, 1'b1, 1'b0, 16'd3);

        wait_ready();
        clear = 1'b1;
        @(posedge clk);
        #1 clear = 1'b0;
        @(negedge clk);
        chk("clr_sum_sq",   32'(sum_sq),   32'd0);
        chk("clr_max_abs",  32'(max_abs),  32'd0);
        chk("clr_sat",      32'(sat),      32'd0);
        chk("clr_skip_cnt", 32'(skip_cnt), 32'd0);
        chk("clr_done",     32'(done),     32'd0);
        chk("clr_ready",    32'(in_ready), 32'd1);
        chk("clr_mse_kept", 32'(mse),      32'd3);

        // Async reset in the middle of a division: sample is dropped
        send(16'd100, 8'd7, 8'd12, c);
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_ready",   32'(in_ready), 32'd1);
        chk("mid_rst_sum_sq",  32'(sum_sq),   32'd0);
        chk("mid_rst_max_abs", 32'(max_abs),  32'd0);
        chk("mid_rst_mse",     32'(mse),      32'd0);
        chk("mid_rst_done",    32'(done),     32'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", 32'(in_ready), 32'd1);
        sample(16'd100, 8'd7, 8'd12, 16'd4, 8'd2, 1'b0, 1'b0, 16'd0);

        w = 0;
        while (exp_q.size() != 0 && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
